// File: rtl/mc_bus_slave_pkg.sv
// Shared types and constants for the MCU memory-controller bus slave.
package mc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    READ     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UNF   = 3;
  localparam int ST_PROTO = 4;
  localparam int ST_TMO   = 5;

  localparam int          TMO_W     = 12;
  localparam logic [11:0] TMO_LIMIT = 12'd4095;

endpackage

// File: rtl/mc_bus_slave_if.sv
// Pin-side bundle of the MCU memory-controller bus (strobes, address, data).
interface mc_bus_slave_if #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6
);
  logic                     mc_ce;
  logic                     mc_we;
  logic                     mc_oe;
  logic [MC_ADD_WIDTH-1:0]  mc_add;
  logic [MC_DATA_WIDTH-1:0] mc_data_in;
  logic [MC_DATA_WIDTH-1:0] mc_data_out;
  logic                     mc_data_oe;

  modport master (
    output mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
    input  mc_data_out, mc_data_oe
  );

  modport slave (
    input  mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
    output mc_data_out, mc_data_oe
  );
endinterface

// File: rtl/mc_bus_slave_sync.sv
// Multi-flop synchroniser for an active-low asynchronous strobe (resets to idle-high).
module mc_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clock) begin
    if (!reset) sync_p <= '1;
    else        sync_p <= {sync_p[STAGES-2:0], async_in};
  end

  assign sync_out = sync_p[STAGES-1];

endmodule

// File: rtl/mc_bus_slave.sv
// MCU memory-controller bus slave: control registers, FIFO window, sticky status.
// Optional bus-hang timeout enabled by defining MC_BUS_TIMEOUT_EN.
module mc_bus_slave
  import mc_bus_pkg::*;
#(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int NUM_REGS      = 8,
  parameter int FIFO_ADDR     = 7,
  parameter int STATUS_ADDR   = 6,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  mc_bus_slave_if.slave                     bus,
  output logic [NUM_REGS*MC_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]               reg_wstb,
  output logic [MC_DATA_WIDTH-1:0]          fifo_wr_data,
  output logic                              fifo_wr_en,
  input  logic                              fifo_full,
  input  logic [MC_DATA_WIDTH-1:0]          fifo_rd_data,
  output logic                              fifo_rd_en,
  input  logic                              fifo_empty,
  output logic                              bus_err
);

  localparam int W  = MC_DATA_WIDTH;
  localparam int AW = MC_ADD_WIDTH;
  localparam logic [AW-1:0] FIFO_A   = AW'(FIFO_ADDR);
  localparam logic [AW-1:0] STATUS_A = AW'(STATUS_ADDR);

  logic ce_s, we_s, oe_s, we_d, oe_d;
  logic we_fall, oe_fall, oe_rise;
  state_t state_q, state_d;
  logic start_wr, start_rd, proto_hit, rd_done, tmo_hit;
  logic [AW-1:0] addr_q;
  logic [W-1:0]  data_q, data_out_q, status_word;
  logic data_oe_q, ovf_err, unf_err, proto_err;
`ifdef MC_BUS_TIMEOUT_EN
  logic              tmo_err;
  logic [TMO_W-1:0]  tmo_cnt;
`endif

  mc_sync #(.STAGES(SYNC_STAGES)) u_sync_ce (.clock(clock), .reset(reset), .async_in(bus.mc_ce), .sync_out(ce_s));
  mc_sync #(.STAGES(SYNC_STAGES)) u_sync_we (.clock(clock), .reset(reset), .async_in(bus.mc_we), .sync_out(we_s));
  mc_sync #(.STAGES(SYNC_STAGES)) u_sync_oe (.clock(clock), .reset(reset), .async_in(bus.mc_oe), .sync_out(oe_s));

  assign we_fall = we_d & ~we_s;
  assign oe_fall = oe_d & ~oe_s;
  assign oe_rise = ~oe_d & oe_s;

  assign bus.mc_data_out = data_out_q;
  assign bus.mc_data_oe  = data_oe_q;

  always_comb begin
    status_word           = '0;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_OVF]   = ovf_err;
    status_word[ST_UNF]   = unf_err;
    status_word[ST_PROTO] = proto_err;
`ifdef MC_BUS_TIMEOUT_EN
    status_word[ST_TMO]   = tmo_err;
`endif
  end

  // FIFO and status windows win over the register range when they overlap.
  function automatic logic [W-1:0] read_word(input logic [AW-1:0] a);
    logic [W-1:0] w;
    w = '0;
    if (a == FIFO_A)        w = fifo_empty ? '0 : fifo_rd_data;
    else if (a == STATUS_A) w = status_word;
    else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (a == AW'(i)) w = reg_q[i*W +: W];
    end
    return w;
  endfunction

  always_comb begin
    state_d   = state_q;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    proto_hit = 1'b0;
    rd_done   = 1'b0;
    tmo_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ce_s && (we_fall || oe_fall) && !we_s && !oe_s) begin
          proto_hit = 1'b1;
          state_d   = WAIT_REL;
        end else if (!ce_s && we_fall) begin
          start_wr = 1'b1;
          state_d  = WRITE;
        end else if (!ce_s && oe_fall) begin
          start_rd = 1'b1;
          state_d  = READ;
        end
      end
      WRITE:    state_d = WAIT_REL;
      READ: begin
        if (oe_rise) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_REL: if (ce_s && we_s && oe_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
`ifdef MC_BUS_TIMEOUT_EN
    if ((state_q == READ || state_q == WAIT_REL) && tmo_cnt == TMO_LIMIT) begin
      tmo_hit = 1'b1;
      rd_done = 1'b0;
      state_d = IDLE;
    end
`endif
  end

`ifdef MC_BUS_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!reset) tmo_cnt <= '0;
    else if ((state_q == READ || state_q == WAIT_REL) && !tmo_hit) tmo_cnt <= tmo_cnt + 12'd1;
    else tmo_cnt <= '0;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      we_d         <= 1'b1;
      oe_d         <= 1'b1;
      addr_q       <= '0;
      data_q       <= '0;
      reg_q        <= '0;
      reg_wstb     <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      fifo_rd_en   <= 1'b0;
      data_out_q   <= '0;
      data_oe_q    <= 1'b0;
      ovf_err      <= 1'b0;
      unf_err      <= 1'b0;
      proto_err    <= 1'b0;
      bus_err      <= 1'b0;
`ifdef MC_BUS_TIMEOUT_EN
      tmo_err      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_d       <= we_s;
      oe_d       <= oe_s;
      reg_wstb   <= '0;
      fifo_wr_en <= 1'b0;
      fifo_rd_en <= 1'b0;

      if (start_wr || start_rd) begin
        addr_q <= bus.mc_add;
        data_q <= bus.mc_data_in;
      end
      if (start_rd) begin
        data_oe_q  <= 1'b1;
        data_out_q <= read_word(bus.mc_add);
      end else if (state_q == READ) begin
        data_out_q <= read_word(addr_q);
      end
      if (proto_hit) proto_err <= 1'b1;

      if (state_q == WRITE) begin
        if (addr_q == FIFO_A) begin
          if (!fifo_full) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= data_q;
          end else begin
            ovf_err <= 1'b1;
          end
        end else if (addr_q == STATUS_A) begin
          if (data_q[ST_OVF])   ovf_err   <= 1'b0;
          if (data_q[ST_UNF])   unf_err   <= 1'b0;
          if (data_q[ST_PROTO]) proto_err <= 1'b0;
`ifdef MC_BUS_TIMEOUT_EN
          if (data_q[ST_TMO])   tmo_err   <= 1'b0;
`endif
        end else begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == AW'(i)) begin
              reg_q[i*W +: W] <= data_q;
              reg_wstb[i]     <= 1'b1;
            end
          end
        end
      end

      if (rd_done) begin
        data_oe_q <= 1'b0;
        if (addr_q == FIFO_A) begin
          if (!fifo_empty) fifo_rd_en <= 1'b1;
          else             unf_err    <= 1'b1;
        end
      end

`ifdef MC_BUS_TIMEOUT_EN
      if (tmo_hit) begin
        data_oe_q <= 1'b0;
        tmo_err   <= 1'b1;
      end
      bus_err <= ovf_err | unf_err | proto_err | tmo_err;
`else
      bus_err <= ovf_err | unf_err | proto_err;
`endif
    end
  end

endmodule

// File: tb/tb_mc_bus_slave.sv
// Directed bench for mc_bus_slave: register, FIFO, status, protocol and hold/timeout cases.
module tb_mc_bus_slave;

  localparam int W = 16;
  localparam int N = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N*W-1:0] reg_q;
  logic [N-1:0]   reg_wstb;
  logic [W-1:0]   fifo_wr_data;
  logic           fifo_wr_en;
  logic           fifo_full = 1'b0;
  logic [W-1:0]   fifo_rd_data = '0;
  logic           fifo_rd_en;
  logic           fifo_empty = 1'b0;
  logic           bus_err;

  int tests  = 0;
  int failed = 0;
  int wstb_cnt [N];
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [W-1:0] push_data [8];

  mc_bus_slave_if #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6)) bus ();

  mc_bus_slave dut (
    .clock(clock), .reset(reset), .bus(bus),
    .reg_q(reg_q), .reg_wstb(reg_wstb),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
    .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  initial for (int i = 0; i < N; i++) wstb_cnt[i] = 0;

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) if (reg_wstb[i] === 1'b1) wstb_cnt[i] = wstb_cnt[i] + 1;
    if (fifo_wr_en === 1'b1) begin
      if (wr_cnt < 8) push_data[wr_cnt] = fifo_wr_data;
      wr_cnt = wr_cnt + 1;
    end
    if (fifo_rd_en === 1'b1) rd_cnt = rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clock);
    bus.mc_ce = 1'b0; bus.mc_add = a; bus.mc_data_in = d;
    repeat (3) @(negedge clock);
    bus.mc_we = 1'b0;
    repeat (6) @(negedge clock);
    bus.mc_we = 1'b1;
    repeat (3) @(negedge clock);
    bus.mc_ce = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [15:0] d,
                          output logic oe_on, output logic oe_off);
    @(negedge clock);
    bus.mc_ce = 1'b0; bus.mc_add = a;
    repeat (3) @(negedge clock);
    bus.mc_oe = 1'b0;
    repeat (3) @(negedge clock);
    oe_on = bus.mc_data_oe;
    repeat (3) @(negedge clock);
    d = bus.mc_data_out;
    bus.mc_oe = 1'b1;
    repeat (4) @(negedge clock);
    oe_off = bus.mc_data_oe;
    bus.mc_ce = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    logic [15:0] rd;
    logic        on, off;
    int          fall_at;
    bus.mc_ce = 1'b1; bus.mc_we = 1'b1; bus.mc_oe = 1'b1;
    bus.mc_add = '0; bus.mc_data_in = '0;

    repeat (3) @(negedge clock);
    check("rst_reg_q", {16'h0, reg_q[15:0] | reg_q[127:112]}, 32'h0);
    check("rst_oe", {31'h0, bus.mc_data_oe}, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);
    check("rst_fifo_wr_en", {31'h0, fifo_wr_en}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    bus_write(6'd0, 16'h00FB);
    check("reg0_value", {16'h0, reg_q[15:0]}, 32'h00FB);
    check("reg0_wstb_cycles", wstb_cnt[0], 1);
    check("other_wstb", wstb_cnt[1] + wstb_cnt[2] + wstb_cnt[5], 0);
    check("other_regs_zero", {31'h0, |reg_q[127:16]}, 32'h0);

    bus_write(6'd7, 16'h08AA);
    bus_write(6'd7, 16'h08FF);
    check("push_count", wr_cnt, 2);
    check("push0_data", {16'h0, push_data[0]}, 32'h08AA);
    check("push1_data", {16'h0, push_data[1]}, 32'h08FF);
    check("fifo_no_reg7", {16'h0, reg_q[127:112]}, 32'h0);

    fifo_full = 1'b1;
    bus_write(6'd7, 16'h81FF);
    check("full_no_push", wr_cnt, 2);
    check("ovf_bus_err", {31'h0, bus_err}, 32'h1);
    bus_read(6'd6, rd, on, off);
    check("status_ovf_full", {16'h0, rd}, 32'h0006);
    fifo_full = 1'b0;
    bus_write(6'd6, 16'h0004);
    check("ovf_cleared_bus_err", {31'h0, bus_err}, 32'h0);
    check("status_no_reg6", {16'h0, reg_q[111:96]}, 32'h0);
    bus_read(6'd6, rd, on, off);
    check("status_clear", {16'h0, rd}, 32'h0000);

    bus_write(6'd1, 16'h0004);
    bus_read(6'd1, rd, on, off);
    check("read1_oe_on", {31'h0, on}, 32'h1);
    check("read1_data", {16'h0, rd}, 32'h0004);
    check("read1_oe_off", {31'h0, off}, 32'h0);

    fifo_rd_data = 16'h1234;
    bus_read(6'd7, rd, on, off);
    check("fifo_read_data", {16'h0, rd}, 32'h1234);
    check("fifo_pop_count", rd_cnt, 1);
    fifo_empty = 1'b1;
    bus_read(6'd7, rd, on, off);
    check("empty_read_data", {16'h0, rd}, 32'h0000);
    check("empty_no_pop", rd_cnt, 1);
    bus_read(6'd6, rd, on, off);
    check("status_unf_empty", {16'h0, rd}, 32'h0009);
    check("unf_bus_err", {31'h0, bus_err}, 32'h1);
    fifo_empty = 1'b0;
    bus_write(6'd6, 16'h0008);

    bus_write(6'd10, 16'h7777);
    bus_read(6'd10, rd, on, off);
    check("unmapped_read", {16'h0, rd}, 32'h0000);

    @(negedge clock);
    bus.mc_ce = 1'b0; bus.mc_add = 6'd0; bus.mc_data_in = 16'hDEAD;
    repeat (3) @(negedge clock);
    bus.mc_we = 1'b0; bus.mc_oe = 1'b0;
    repeat (6) @(negedge clock);
    check("proto_no_oe", {31'h0, bus.mc_data_oe}, 32'h0);
    bus.mc_we = 1'b1; bus.mc_oe = 1'b1;
    repeat (3) @(negedge clock);
    bus.mc_ce = 1'b1;
    repeat (4) @(negedge clock);
    check("proto_regs_kept", reg_q[31:0], 32'h0004_00FB);
    check("proto_no_wstb", wstb_cnt[0], 1);
    bus_read(6'd6, rd, on, off);
    check("status_proto", {16'h0, rd}, 32'h0010);
    bus_write(6'd6, 16'h0010);
    check("proto_cleared", {31'h0, bus_err}, 32'h0);
    bus_write(6'd2, 16'h5555);
    bus_read(6'd2, rd, on, off);
    check("after_proto_rw", {16'h0, rd}, 32'h5555);

    @(negedge clock);
    bus.mc_ce = 1'b0; bus.mc_add = 6'd1;
    repeat (3) @(negedge clock);
    bus.mc_oe = 1'b0;
    fall_at = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (i > 2 && fall_at < 0 && bus.mc_data_oe !== 1'b1) fall_at = i;
    end
`ifdef MC_BUS_TIMEOUT_EN
    check("tmo_fall_cycle", fall_at, 4098);
    check("tmo_bus_err", {31'h0, bus_err}, 32'h1);
`else
    check("hold_no_timeout", fall_at, -1);
    check("hold_bus_err", {31'h0, bus_err}, 32'h0);
`endif
    bus.mc_oe = 1'b1;
    repeat (4) @(negedge clock);
    check("hold_release_oe", {31'h0, bus.mc_data_oe}, 32'h0);
    bus.mc_ce = 1'b1;
    repeat (4) @(negedge clock);
`ifdef MC_BUS_TIMEOUT_EN
    bus_read(6'd6, rd, on, off);
    check("status_tmo", {16'h0, rd}, 32'h0020);
`endif
    check("hold_no_pop", rd_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
